// File: rtl/reg_dest_scoreboard_pkg.sv
// Shared sizing and types for the destination-register scoreboard.
// Holds the register count, index width and per-register counter width.
package reg_sb_pkg;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 2;

  typedef logic [AW-1:0]    reg_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = cnt_t'((1 << CNT_W) - 1);
  localparam cnt_t CNT_ONE = cnt_t'(1);
endpackage

// File: rtl/reg_dest_scoreboard_if.sv
// Issue / write-back / flush bundle between the pipeline and the scoreboard.
// The pipeline side is the master; the scoreboard answers with stall.
interface reg_dest_scoreboard_if;
  logic               issue_valid;
  logic               issue_wr_en;
  reg_sb_pkg::reg_idx_t issue_dst;
  logic               issue_use_rs;
  reg_sb_pkg::reg_idx_t issue_rs;
  logic               issue_use_rt;
  reg_sb_pkg::reg_idx_t issue_rt;
  logic               stall;
  logic               wb_valid;
  reg_sb_pkg::reg_idx_t wb_dst;
  logic               flush;

  modport master (
    output issue_valid, issue_wr_en, issue_dst,
    output issue_use_rs, issue_rs, issue_use_rt, issue_rt,
    output wb_valid, wb_dst, flush,
    input  stall
  );

  modport slave (
    input  issue_valid, issue_wr_en, issue_dst,
    input  issue_use_rs, issue_rs, issue_use_rt, issue_rt,
    input  wb_valid, wb_dst, flush,
    output stall
  );
endinterface

// File: rtl/reg_dest_scoreboard_sb_entry.sv
// One pending-write counter for a single architectural register.
// err flags a write-back that arrives while nothing is pending.
module sb_entry
  import reg_sb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec_req,
  input  logic flush,
  output cnt_t count,
  output logic busy,
  output logic err
);

  logic dec;
  cnt_t count_next;

  assign dec = dec_req & (count != '0);
  assign err = dec_req & (count == '0) & ~flush;

  always_comb begin
    count_next = count;
    if (flush)
      count_next = '0;
    else if (inc && !dec)
      count_next = count + CNT_ONE;
    else if (dec && !inc)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      count <= count_next;
      busy  <= (count_next != '0);
    end
  end

endmodule

// File: rtl/reg_dest_scoreboard.sv
// RAW-hazard scoreboard for the 5-bit destination-register path.
// Optional macro REG_DEST_SCOREBOARD_WB_BYPASS_EN masks a hazard whose last write retires this cycle.
module reg_dest_scoreboard
  import reg_sb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  reg_dest_scoreboard_if.slave   sb,
  output logic [NREG-1:0]        busy_vec,
  output logic                   underflow_err
);

  if ((1 << AW) != NREG) begin : g_size_check
    $error("reg_dest_scoreboard: 2**AW must equal NREG");
  end

  cnt_t            cnt [NREG];
  logic [NREG-1:0] busy_w;
  logic [NREG-1:0] ent_err;
  cnt_t            cnt_rs, cnt_rt, cnt_dst;
  logic            hazard_rs, hazard_rt, sat;
  logic            byp_rs, byp_rt;
  logic            stall_w, accept;

  // r0 is hardwired: never counted, never busy, never underflows.
  assign cnt[0]     = '0;
  assign busy_w[0]  = 1'b0;
  assign ent_err[0] = 1'b0;

  always_comb begin
    cnt_rs    = cnt[sb.issue_rs];
    cnt_rt    = cnt[sb.issue_rt];
    cnt_dst   = cnt[sb.issue_dst];
    hazard_rs = sb.issue_use_rs & (sb.issue_rs != '0) & (cnt_rs != '0);
    hazard_rt = sb.issue_use_rt & (sb.issue_rt != '0) & (cnt_rt != '0);
    sat       = sb.issue_wr_en & (sb.issue_dst != '0) & (cnt_dst == CNT_MAX);
`ifdef REG_DEST_SCOREBOARD_WB_BYPASS_EN
    // Last outstanding write retires now; the register file forwards it.
    byp_rs = sb.wb_valid & (sb.wb_dst == sb.issue_rs) & (cnt_rs == CNT_ONE);
    byp_rt = sb.wb_valid & (sb.wb_dst == sb.issue_rt) & (cnt_rt == CNT_ONE);
`else
    byp_rs = 1'b0;
    byp_rt = 1'b0;
`endif
    stall_w = sb.issue_valid &
              ((hazard_rs & ~byp_rs) | (hazard_rt & ~byp_rt) | sat);
    accept  = sb.issue_valid & ~stall_w;
  end

  assign sb.stall = stall_w;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    logic inc, dec_req;
    assign inc     = accept & sb.issue_wr_en & (sb.issue_dst == reg_idx_t'(i));
    assign dec_req = sb.wb_valid & (sb.wb_dst == reg_idx_t'(i));

    sb_entry u_entry (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc),
      .dec_req (dec_req),
      .flush   (sb.flush),
      .count   (cnt[i]),
      .busy    (busy_w[i]),
      .err     (ent_err[i])
    );
  end

  assign busy_vec = busy_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      underflow_err <= 1'b0;
    else if (|ent_err)
      underflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Self-checking bench: directed vector table, hand sequences, then random traffic vs a counting model.
module tb_reg_dest_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] busy_vec;
  logic        underflow_err;
  int          checks = 0;
  int          failures = 0;

  reg_dest_scoreboard_if sb_if();

  reg_dest_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sb            (sb_if),
    .busy_vec      (busy_vec),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  dst;
    logic        urs;
    logic [4:0]  rs;
    logic        urt;
    logic [4:0]  rt;
    logic        wbv;
    logic [4:0]  wbd;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  // Reference model: pending writes per register as plain integers.
  int   m_cnt [32];
  logic m_err;

  function automatic logic [31:0] bit_of(input int r);
    logic [31:0] one;
    one = 32'h1;
    return one << r;
  endfunction

  function automatic vec_t mk(input logic v, we, input int dst, input logic urs, input int rs,
                              input logic urt, input int rt, input logic wbv, input int wbd,
                              input logic fl, input logic e_stall, input logic [31:0] e_busy,
                              input logic e_err);
    vec_t t;
    t.v = v; t.we = we; t.dst = 5'(dst); t.urs = urs; t.rs = 5'(rs);
    t.urt = urt; t.rt = 5'(rt); t.wbv = wbv; t.wbd = 5'(wbd); t.fl = fl;
    t.e_stall = e_stall; t.e_busy = e_busy; t.e_err = e_err;
    return t;
  endfunction

  function automatic logic m_stall(input vec_t t);
    logic h_rs, h_rt, sat;
    h_rs = t.urs && t.rs != 0 && m_cnt[t.rs] != 0;
    h_rt = t.urt && t.rt != 0 && m_cnt[t.rt] != 0;
`ifdef REG_DEST_SCOREBOARD_WB_BYPASS_EN
    if (t.wbv && t.wbd == t.rs && m_cnt[t.rs] == 1) h_rs = 1'b0;
    if (t.wbv && t.wbd == t.rt && m_cnt[t.rt] == 1) h_rt = 1'b0;
`endif
    sat = t.we && t.dst != 0 && m_cnt[t.dst] == 3;
    return t.v && (h_rs || h_rt || sat);
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) b = b | bit_of(i);
    return b;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_err = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Drives one cycle: stall sampled at the falling edge, state sampled 1ns after the rising edge.
  task automatic run_cycle(input vec_t t, output logic got_stall, output logic exp_stall,
                           output logic [31:0] got_busy, output logic got_err);
    int nxt [32];
    sb_if.issue_valid  = t.v;
    sb_if.issue_wr_en  = t.we;
    sb_if.issue_dst    = t.dst;
    sb_if.issue_use_rs = t.urs;
    sb_if.issue_rs     = t.rs;
    sb_if.issue_use_rt = t.urt;
    sb_if.issue_rt     = t.rt;
    sb_if.wb_valid     = t.wbv;
    sb_if.wb_dst       = t.wbd;
    sb_if.flush        = t.fl;
    @(negedge clk);
    got_stall = sb_if.stall;
    exp_stall = m_stall(t);
    nxt = m_cnt;
    if (t.fl) begin
      for (int i = 0; i < 32; i++) nxt[i] = 0;
    end else begin
      if (t.v && !exp_stall && t.we && t.dst != 0) nxt[t.dst] = nxt[t.dst] + 1;
      if (t.wbv && t.wbd != 0) begin
        if (m_cnt[t.wbd] == 0) m_err = 1'b1;
        else nxt[t.wbd] = nxt[t.wbd] - 1;
      end
    end
    @(posedge clk);
    m_cnt = nxt;
    #1;
    got_busy = busy_vec;
    got_err  = underflow_err;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_reset();
    check("reset_busy", busy_vec, 32'h0);
    check("reset_err", {31'h0, underflow_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t        tbl[$];
  vec_t        t;
  logic        gs, es, ge;
  logic [31:0] gb;
  logic [31:0] b3, b34, b345;

  initial begin
    sb_if.issue_valid = 0; sb_if.issue_wr_en = 0; sb_if.issue_dst = 0;
    sb_if.issue_use_rs = 0; sb_if.issue_rs = 0; sb_if.issue_use_rt = 0; sb_if.issue_rt = 0;
    sb_if.wb_valid = 0; sb_if.wb_dst = 0; sb_if.flush = 0;
    m_reset();
    #3;
    check("reset_stall", {31'h0, sb_if.stall}, 32'h0);
    do_reset();

    b3   = bit_of(3);
    b34  = b3 | bit_of(4);
    b345 = b34 | bit_of(5);
    //         v  we dst urs rs urt rt wbv wbd fl  stall busy              err
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, bit_of(8), 0));
    tbl.push_back(mk(1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, bit_of(8), 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, b3, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, b3, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, b3, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, b3, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 1, b3, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, b3, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, b3, 0));
    tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, b34, 0));
    tbl.push_back(mk(1, 1, 4, 0, 0, 0, 0, 1, 4, 0, 0, b34, 0));
    tbl.push_back(mk(1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1, b34, 0));
    tbl.push_back(mk(1, 1, 5, 1, 5, 0, 0, 0, 0, 0, 0, b345, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, b345, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, b345, 1));
    tbl.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, b345 | bit_of(2), 1));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, b345 | bit_of(2) | bit_of(7), 1));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 32'h0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      run_cycle(tbl[i], gs, es, gb, ge);
      check($sformatf("vec%0d_stall", i), {31'h0, gs}, {31'h0, tbl[i].e_stall});
      check($sformatf("vec%0d_busy", i), gb, tbl[i].e_busy);
      check($sformatf("vec%0d_err", i), {31'h0, ge}, {31'h0, tbl[i].e_err});
    end

    // Asynchronous reset in the middle of a cycle clears everything.
    run_cycle(mk(1, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), gs, es, gb, ge);
    #2;
    do_reset();

    // Write-back underflow is suppressed when flush is active the same cycle.
    run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0), gs, es, gb, ge);
    check("flush_wb_no_err", {31'h0, ge}, 32'h0);

    // Source read in the same cycle as the retiring write-back.
    run_cycle(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), gs, es, gb, ge);
    check("byp_setup_busy", gb, bit_of(6));
    run_cycle(mk(1, 0, 0, 1, 6, 0, 0, 1, 6, 0, 0, 0, 0), gs, es, gb, ge);
`ifdef REG_DEST_SCOREBOARD_WB_BYPASS_EN
    check("byp_same_cycle_stall", {31'h0, gs}, 32'h0);
`else
    check("byp_same_cycle_stall", {31'h0, gs}, 32'h1);
`endif
    check("byp_after_busy", gb, 32'h0);
    run_cycle(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0), gs, es, gb, ge);
    check("byp_next_stall", {31'h0, gs}, 32'h0);

    // Random traffic on a small register window for dense hazards.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      t = mk(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             ($urandom_range(0, 2) == 0), $urandom_range(0, 7), ($urandom_range(0, 40) == 0),
             0, 0, 0);
      run_cycle(t, gs, es, gb, ge);
      check($sformatf("rnd%0d_stall", n), {31'h0, gs}, {31'h0, es});
      check($sformatf("rnd%0d_busy", n), gb, m_busy());
      check($sformatf("rnd%0d_err", n), {31'h0, ge}, {31'h0, m_err});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
